// File: rtl/pipe_mips32_p.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mips32_p
// Purpose  : Five-stage (IF/ID/EX/MEM/WB) MIPS-like 32-bit pipeline. It runs
//            on a single clock and uses one unified instruction/data memory.
//            RAW hazards are resolved by interlock, or by forwarding when
//            PIPE_FWD_EN is defined. Branches resolve in EX.
// Macro    : PIPE_FWD_EN - enables EX/MEM and MEM/WB forwarding into EX.
//            When enabled, only a load-use hazard costs a stall.
// Ports    : clk1    - clock, rising edge
//            rst     - synchronous active-high reset (memory is preserved)
//            ld_we   - memory load strobe
//            ld_addr - memory load word address
//            ld_data - memory load data
//            halted  - sticky; set when HLT retires
//            pc      - current fetch PC
//            retired - count of retired instructions (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mips32_p #(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic                         clk1,
    input  logic                         rst,
    input  logic                         ld_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [31:0]                  ld_data,
    output logic                         halted,
    output logic [31:0]                  pc,
    output logic [31:0]                  retired
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_AND   = 6'b000010;
    localparam logic [5:0] c_OP_OR    = 6'b000011;
    localparam logic [5:0] c_OP_SLT   = 6'b000100;
    localparam logic [5:0] c_OP_MUL   = 6'b000101;
    localparam logic [5:0] c_OP_LW    = 6'b001000;
    localparam logic [5:0] c_OP_SW    = 6'b001001;
    localparam logic [5:0] c_OP_ADDI  = 6'b001010;
    localparam logic [5:0] c_OP_SUBI  = 6'b001011;
    localparam logic [5:0] c_OP_SLTI  = 6'b001100;
    localparam logic [5:0] c_OP_BNEQZ = 6'b001101;
    localparam logic [5:0] c_OP_BEQZ  = 6'b001110;
    localparam logic [5:0] c_OP_HLT   = 6'b111111;

    // Word addresses wrap modulo MEM_DEPTH. For a power-of-two depth this
    // is a simple truncation.
    function automatic logic [ADDR_W-1:0] mem_idx(input logic [31:0] a);
        if ((MEM_DEPTH & (MEM_DEPTH - 1)) == 0) return a[ADDR_W-1:0];
        else                                   return ADDR_W'(a % 32'(MEM_DEPTH));
    endfunction

    logic [31:0] r_mem  [MEM_DEPTH];
    logic [31:0] r_regs [32];

    // Architectural / control state
    logic [31:0] r_pc;
    logic        r_halted;
    logic [31:0] r_retired;
    logic        r_stop;       // HLT has left ID, so fetch stays off

    // IF/ID
    logic        r_ifid_v;
    logic [31:0] r_ifid_ir;
    logic [31:0] r_ifid_npc;
    // ID/EX
    logic        r_idex_v;
    logic [5:0]  r_idex_op;
    logic [4:0]  r_idex_dst;   // 0 means "writes no register"
    logic [31:0] r_idex_a, r_idex_b, r_idex_imm, r_idex_npc;
`ifdef PIPE_FWD_EN
    logic [4:0]  r_idex_rs, r_idex_rt;
`endif
    // EX/MEM
    logic        r_exmem_v;
    logic [5:0]  r_exmem_op;
    logic [4:0]  r_exmem_dst;
    logic [31:0] r_exmem_alu, r_exmem_b;
    // MEM/WB
    logic        r_memwb_v;
    logic        r_memwb_hlt;
    logic [4:0]  r_memwb_dst;
    logic [31:0] r_memwb_res;

    // ---------------- ID decode ----------------
    logic [5:0]  w_id_op;
    logic [4:0]  w_id_rs, w_id_rt, w_id_dst;
    logic        w_id_use_rs, w_id_use_rt, w_id_hlt;
    logic [31:0] w_id_a, w_id_b, w_id_imm;

    always_comb begin
        w_id_op     = r_ifid_ir[31:26];
        w_id_rs     = r_ifid_ir[25:21];
        w_id_rt     = r_ifid_ir[20:16];
        w_id_imm    = {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};
        w_id_dst    = 5'd0;
        w_id_use_rs = 1'b0;
        w_id_use_rt = 1'b0;
        case (w_id_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SLT, c_OP_MUL: begin
                w_id_dst    = r_ifid_ir[15:11];
                w_id_use_rs = 1'b1;
                w_id_use_rt = 1'b1;
            end
            c_OP_LW, c_OP_ADDI, c_OP_SUBI, c_OP_SLTI: begin
                w_id_dst    = w_id_rt;
                w_id_use_rs = 1'b1;
            end
            c_OP_SW: begin
                w_id_use_rs = 1'b1;
                w_id_use_rt = 1'b1;
            end
            c_OP_BNEQZ, c_OP_BEQZ: w_id_use_rs = 1'b1;
            default: ;
        endcase
        // Register read with write-through of the value retiring this cycle.
        if (w_id_rs == 5'd0)                                   w_id_a = 32'd0;
        else if (r_memwb_v && r_memwb_dst == w_id_rs)          w_id_a = r_memwb_res;
        else                                                   w_id_a = r_regs[w_id_rs];
        if (w_id_rt == 5'd0)                                   w_id_b = 32'd0;
        else if (r_memwb_v && r_memwb_dst == w_id_rt)          w_id_b = r_memwb_res;
        else                                                   w_id_b = r_regs[w_id_rt];
    end

    assign w_id_hlt = r_ifid_v && (w_id_op == c_OP_HLT);

    // ---------------- Hazard detection ----------------
    logic w_hz_ex, w_stall;
    assign w_hz_ex = r_idex_v && (r_idex_dst != 5'd0) &&
                     ((w_id_use_rs && r_idex_dst == w_id_rs) ||
                      (w_id_use_rt && r_idex_dst == w_id_rt));
`ifdef PIPE_FWD_EN
    // Only a load result is too late to forward into the next instruction.
    assign w_stall = r_ifid_v && w_hz_ex && (r_idex_op == c_OP_LW);
`else
    logic w_hz_mem;
    assign w_hz_mem = r_exmem_v && (r_exmem_dst != 5'd0) &&
                      ((w_id_use_rs && r_exmem_dst == w_id_rs) ||
                       (w_id_use_rt && r_exmem_dst == w_id_rt));
    assign w_stall  = r_ifid_v && (w_hz_ex || w_hz_mem);
`endif

    // ---------------- EX ----------------
    logic [31:0] w_ex_a, w_ex_b, w_ex_alu, w_br_target;
    logic        w_br_cond, w_br_taken;

    always_comb begin
        w_ex_a = r_idex_a;
        w_ex_b = r_idex_b;
`ifdef PIPE_FWD_EN
        // The younger producer (EX/MEM) overrides the older one (MEM/WB).
        if (r_memwb_v && r_memwb_dst != 5'd0 && r_memwb_dst == r_idex_rs) w_ex_a = r_memwb_res;
        if (r_exmem_v && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rs) w_ex_a = r_exmem_alu;
        if (r_memwb_v && r_memwb_dst != 5'd0 && r_memwb_dst == r_idex_rt) w_ex_b = r_memwb_res;
        if (r_exmem_v && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rt) w_ex_b = r_exmem_alu;
`endif
        w_ex_alu  = 32'd0;
        w_br_cond = 1'b0;
        case (r_idex_op)
            c_OP_ADD:                     w_ex_alu = w_ex_a + w_ex_b;
            c_OP_SUB:                     w_ex_alu = w_ex_a - w_ex_b;
            c_OP_AND:                     w_ex_alu = w_ex_a & w_ex_b;
            c_OP_OR:                      w_ex_alu = w_ex_a | w_ex_b;
            c_OP_SLT:                     w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(w_ex_b)};
            c_OP_MUL:                     w_ex_alu = w_ex_a * w_ex_b;
            c_OP_LW, c_OP_SW, c_OP_ADDI:  w_ex_alu = w_ex_a + r_idex_imm;
            c_OP_SUBI:                    w_ex_alu = w_ex_a - r_idex_imm;
            c_OP_SLTI:                    w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(r_idex_imm)};
            c_OP_BNEQZ:                   w_br_cond = (w_ex_a != 32'd0);
            c_OP_BEQZ:                    w_br_cond = (w_ex_a == 32'd0);
            default: ;
        endcase
    end

    assign w_br_taken  = r_idex_v && w_br_cond;
    assign w_br_target = r_idex_npc + r_idex_imm;

    // ---------------- IF / MEM ----------------
    logic        w_fetch_en, w_if_load;
    logic [31:0] w_if_ir, w_mem_rdata;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_fetch_en  = !r_stop && !w_id_hlt;
    assign w_if_load   = !w_br_taken && !w_stall && w_fetch_en;
    assign w_if_ir     = r_mem[mem_idx(r_pc)];
    assign w_mem_addr  = mem_idx(r_exmem_alu);
    assign w_mem_rdata = r_mem[w_mem_addr];

    // ---------------- Control state ----------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_halted  <= 1'b0;
            r_retired <= 32'd0;
            r_stop    <= 1'b0;
            r_ifid_v  <= 1'b0;
            r_idex_v  <= 1'b0;
            r_exmem_v <= 1'b0;
            r_memwb_v <= 1'b0;
        end else begin
            // A taken branch overrides a simultaneous stall.
            if (w_br_taken) begin
                r_pc     <= w_br_target;
                r_ifid_v <= 1'b0;
            end else if (!w_stall) begin
                if (w_fetch_en) begin
                    r_pc     <= r_pc + 32'd1;
                    r_ifid_v <= 1'b1;
                end else begin
                    r_ifid_v <= 1'b0;
                end
            end
            if (w_id_hlt && !w_br_taken) r_stop <= 1'b1;
            r_idex_v  <= r_ifid_v && !w_stall && !w_br_taken;
            r_exmem_v <= r_idex_v;
            r_memwb_v <= r_exmem_v;
            if (r_memwb_v)               r_retired <= r_retired + 32'd1;
            if (r_memwb_v && r_memwb_hlt) r_halted <= 1'b1;
        end
    end

    // ---------------- Datapath registers (qualified by valid bits) ----------------
    always_ff @(posedge clk1) begin
        if (w_if_load) begin
            r_ifid_ir  <= w_if_ir;
            r_ifid_npc <= r_pc + 32'd1;
        end
        r_idex_op   <= w_id_op;
        r_idex_dst  <= w_id_dst;
        r_idex_a    <= w_id_a;
        r_idex_b    <= w_id_b;
        r_idex_imm  <= w_id_imm;
        r_idex_npc  <= r_ifid_npc;
`ifdef PIPE_FWD_EN
        r_idex_rs   <= w_id_use_rs ? w_id_rs : 5'd0;
        r_idex_rt   <= w_id_use_rt ? w_id_rt : 5'd0;
`endif
        r_exmem_op  <= r_idex_op;
        r_exmem_dst <= r_idex_dst;
        r_exmem_alu <= w_ex_alu;
        r_exmem_b   <= w_ex_b;
        r_memwb_hlt <= (r_exmem_op == c_OP_HLT);
        r_memwb_dst <= r_exmem_dst;
        r_memwb_res <= (r_exmem_op == c_OP_LW) ? w_mem_rdata : r_exmem_alu;
    end

    // ---------------- Register file (R0 is never written) ----------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (r_memwb_v && r_memwb_dst != 5'd0) begin
            r_regs[r_memwb_dst] <= r_memwb_res;
        end
    end

    // ---------------- Memory: the SW store is written last, so it wins ----------------
    always_ff @(posedge clk1) begin
        if (ld_we) r_mem[ld_addr] <= ld_data;
        if (!rst && r_exmem_v && r_exmem_op == c_OP_SW) r_mem[w_mem_addr] <= r_exmem_b;
    end

    assign pc      = r_pc;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mips32_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mips32_p
// Purpose  : Directed self-checking bench for pipe_mips32_p. Small programs
//            are loaded through the ld_* port while reset is held, then run
//            until halted. Results are compared with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mips32_p;
    localparam int MEM_DEPTH = 1024;
    localparam int AW        = 10;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_BEQZ = 6'b001110;
    localparam logic [5:0] OP_NOP  = 6'b010000;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    // Edges from reset release to halted becoming visible.
`ifdef PIPE_FWD_EN
    localparam int EXP_RAW_CYC = 7;
    localparam int EXP_LU_CYC  = 9;
`else
    localparam int EXP_RAW_CYC = 9;
    localparam int EXP_LU_CYC  = 12;
`endif

    logic          clk1 = 1'b0;
    logic          rst  = 1'b1;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;
    logic          halted;
    logic [31:0]   pc;
    logic [31:0]   retired;

    int total = 0;
    int bad   = 0;

    pipe_mips32_p #(.MEM_DEPTH(MEM_DEPTH), .RESET_PC(32'd0)) dut (
        .clk1    (clk1),
        .rst     (rst),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .halted  (halted),
        .pc      (pc),
        .retired (retired)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic run(input int budget, output int n);
        rst = 1'b0;
        n   = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic load_prog_lw_sw();
        rst = 1'b1;
        poke(0, enc_i(OP_ADDI, 0, 1, 120));
        poke(1, enc_i(OP_LW,   1, 2, 0));
        poke(2, enc_i(OP_ADDI, 2, 2, 45));
        poke(3, enc_i(OP_SW,   1, 2, 1));
        poke(4, enc_i(OP_HLT,  0, 0, 0));
        poke(120, 32'd85);
        poke(121, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (pc !== 32'd0)      begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
        total++; if (halted !== 1'b0)   begin bad++; $display("FAIL reset_halted: got %0b want 0", halted); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
    endtask

    task automatic test_load_store();
        int n;
        load_prog_lw_sw();
        run(300, n);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL ls_halted: got %0b want 1", halted); end
        total++; if (retired !== 32'd5) begin bad++; $display("FAIL ls_retired: got %0d want 5", retired); end
        total++; if (dut.r_mem[121] !== 32'd130) begin bad++; $display("FAIL ls_mem121: got %0d want 130", dut.r_mem[121]); end
        total++; if (dut.r_regs[1] !== 32'd120) begin bad++; $display("FAIL ls_r1: got %0d want 120", dut.r_regs[1]); end
        total++; if (dut.r_regs[2] !== 32'd130) begin bad++; $display("FAIL ls_r2: got %0d want 130", dut.r_regs[2]); end
    endtask

    task automatic test_raw_timing();
        int n;
        rst = 1'b1;
        poke(0, enc_i(OP_ADDI, 0, 1, 7));
        poke(1, enc_r(OP_ADD, 1, 1, 2));
        poke(2, enc_i(OP_HLT, 0, 0, 0));
        run(300, n);
        total++; if (dut.r_regs[2] !== 32'd14) begin bad++; $display("FAIL raw_r2: got %0d want 14", dut.r_regs[2]); end
        total++; if (n != EXP_RAW_CYC) begin bad++; $display("FAIL raw_cycles: got %0d want %0d", n, EXP_RAW_CYC); end
        total++; if (retired !== 32'd3) begin bad++; $display("FAIL raw_retired: got %0d want 3", retired); end
    endtask

    task automatic test_load_use();
        int n;
        rst = 1'b1;
        poke(0, enc_i(OP_ADDI, 0, 1, 120));
        poke(1, enc_i(OP_LW,   1, 2, 0));
        poke(2, enc_r(OP_ADD,  2, 2, 3));
        poke(3, enc_i(OP_HLT,  0, 0, 0));
        poke(120, 32'd85);
        run(300, n);
        total++; if (dut.r_regs[3] !== 32'd170) begin bad++; $display("FAIL lu_r3: got %0d want 170", dut.r_regs[3]); end
        total++; if (n != EXP_LU_CYC) begin bad++; $display("FAIL lu_cycles: got %0d want %0d", n, EXP_LU_CYC); end
    endtask

    task automatic test_branch();
        int n;
        rst = 1'b1;
        poke(0, enc_i(OP_ADDI, 0, 1, 0));
        poke(1, enc_i(OP_BEQZ, 1, 0, 2));
        poke(2, enc_i(OP_ADDI, 0, 4, 1));
        poke(3, enc_i(OP_ADDI, 0, 4, 2));
        poke(4, enc_i(OP_ADDI, 0, 5, 3));
        poke(5, enc_i(OP_HLT,  0, 0, 0));
        run(300, n);
        total++; if (dut.r_regs[4] !== 32'd0) begin bad++; $display("FAIL br_r4: got %0d want 0", dut.r_regs[4]); end
        total++; if (dut.r_regs[5] !== 32'd3) begin bad++; $display("FAIL br_r5: got %0d want 3", dut.r_regs[5]); end
        total++; if (retired !== 32'd4) begin bad++; $display("FAIL br_retired: got %0d want 4", retired); end
        total++; if (pc !== 32'd6) begin bad++; $display("FAIL br_pc: got %0d want 6", pc); end
        repeat (5) tick();
        total++; if (retired !== 32'd4 || pc !== 32'd6 || halted !== 1'b1) begin
            bad++; $display("FAIL halt_sticky: got retired=%0d pc=%0d halted=%0b want 4 6 1", retired, pc, halted);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        load_prog_lw_sw();
        rst = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        total++; if (pc !== 32'd0)      begin bad++; $display("FAIL mid_pc: got %0d want 0", pc); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL mid_retired: got %0d want 0", retired); end
        total++; if (halted !== 1'b0)   begin bad++; $display("FAIL mid_halted: got %0b want 0", halted); end
        total++; if (dut.r_mem[121] !== 32'd0) begin bad++; $display("FAIL mid_nowrite: got %0d want 0", dut.r_mem[121]); end
        run(300, n);
        total++; if (dut.r_mem[121] !== 32'd130) begin bad++; $display("FAIL mid_rerun_mem: got %0d want 130", dut.r_mem[121]); end
        total++; if (retired !== 32'd5) begin bad++; $display("FAIL mid_rerun_retired: got %0d want 5", retired); end
    endtask

    task automatic test_r0_and_collision();
        int n;
        rst = 1'b1;
        poke(0, enc_i(OP_ADDI, 0, 8, 77));
        poke(1, enc_i(OP_NOP,  0, 0, 0));
        poke(2, enc_i(OP_NOP,  0, 0, 0));
        poke(3, enc_i(OP_SW,   0, 8, 130));
        poke(4, enc_i(OP_ADDI, 0, 0, 5));
        poke(5, enc_i(OP_ADDI, 0, 7, 9));
        poke(6, enc_i(OP_HLT,  0, 0, 0));
        poke(130, 32'd0);
        rst = 1'b0;
        // The SW is in MEM during the 7th edge after reset release.
        repeat (6) tick();
        ld_we   = 1'b1;
        ld_addr = AW'(130);
        ld_data = 32'h0000_0055;
        tick();
        ld_we   = 1'b0;
        run(300, n);
        total++; if (dut.r_mem[130] !== 32'd77) begin bad++; $display("FAIL collide_sw_wins: got %0d want 77", dut.r_mem[130]); end
        total++; if (dut.r_regs[7] !== 32'd9) begin bad++; $display("FAIL r0_read: got %0d want 9", dut.r_regs[7]); end
        total++; if (dut.r_regs[0] !== 32'd0) begin bad++; $display("FAIL r0_hold: got %0d want 0", dut.r_regs[0]); end
        total++; if (retired !== 32'd7) begin bad++; $display("FAIL r0_retired: got %0d want 7", retired); end
        poke(131, 32'hA5A5_0001);
        total++; if (dut.r_mem[131] !== 32'hA5A5_0001) begin bad++; $display("FAIL ld_after_halt: got %h want a5a50001", dut.r_mem[131]); end
        total++; if (pc !== 32'd7 || retired !== 32'd7) begin
            bad++; $display("FAIL halted_frozen: got pc=%0d retired=%0d want 7 7", pc, retired);
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_raw_timing();
        test_load_use();
        test_branch();
        test_reset_mid();
        test_r0_and_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
